// File: rtl/riscv_pkg.sv
// Shared core types: decoded op encoding, LSU sequencing states and access-size helpers.
// Used by the decoder, the load/store unit and writeback.
package riscv_pkg;

   typedef enum logic [5:0] {
      CU_LUI = 6'd0, CU_AUIPC, CU_JAL, CU_JALR,
      CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
      CU_LB = 6'd10, CU_LH, CU_LW, CU_LBU, CU_LHU,
      CU_SB = 6'd15, CU_SH, CU_SW,
      CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
      CU_SLLI, CU_SRLI, CU_SRAI,
      CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
      CU_ERROR
   } cu_op_t;

   typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

   function automatic logic is_load(cu_op_t op);
      return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
   endfunction

   function automatic logic is_store(cu_op_t op);
      return op inside {CU_SB, CU_SH, CU_SW};
   endfunction

   function automatic lsu_size_t op_size(cu_op_t op);
      case (op)
         CU_LB, CU_LBU, CU_SB: return SZ_BYTE;
         CU_LH, CU_LHU, CU_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   // Only meaningful for memory ops; callers gate with is_load/is_store.
   function automatic logic is_misaligned(cu_op_t op, logic [1:0] offset);
      case (op_size(op))
         SZ_HALF: return offset[0];
         SZ_WORD: return |offset;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Data-memory bus: single outstanding req/ack transaction with byte enables.
interface lsu_bus_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication / byte enables, and right-aligned,
// zero-filled load extraction. Purely combinational.
module lsu_lane_align
   import riscv_pkg::*;
(
   input  lsu_size_t   st_size,
   input  logic [1:0]  st_offset,
   input  logic [31:0] st_data,
   output logic [31:0] wdata,
   output logic [3:0]  sel,
   input  lsu_size_t   ld_size,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   always_comb begin
      wdata = st_data;
      sel   = 4'b1111;
      case (st_size)
         SZ_BYTE: begin
            wdata = {4{st_data[7:0]}};
            sel   = 4'b0001 << st_offset;
         end
         SZ_HALF: begin
            wdata = {2{st_data[15:0]}};
            sel   = st_offset[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Sign/zero extension happens in writeback, so upper bits are always zero here.
   always_comb begin
      ld_data = rdata;
      case (ld_size)
         SZ_BYTE: begin
            case (ld_offset)
               2'd0:    ld_data = {24'b0, rdata[7:0]};
               2'd1:    ld_data = {24'b0, rdata[15:8]};
               2'd2:    ld_data = {24'b0, rdata[23:16]};
               default: ld_data = {24'b0, rdata[31:24]};
            endcase
         end
         SZ_HALF: ld_data = {16'b0, ld_offset[1] ? rdata[31:16] : rdata[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: launches one bus transaction per aligned memory op, stalls the
// core through IDLE->REQ->DONE, and hands a right-aligned load word to writeback.
module lsu_bus_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic               clk,
   input  logic               nRst,
   input  logic               en,
   input  logic [5:0]         cuOP,
   input  logic [31:0]        addr,
   input  logic [31:0]        rs2,
   output logic [31:0]        memload,
   output logic               stall,
   output logic               misaligned,
   output logic               bus_err,
   lsu_bus_ctrl_if.master     bus
);

   cu_op_t      op;
   lsu_state_t  state, state_next;
   logic        mem_op, bad_align, launch, ack, expire;
   logic [TO_W-1:0] count;
   logic        err_flag;
   logic [31:0] addr_q, wdata_q, st_wdata, ld_data;
   logic        we_q;
   logic [3:0]  sel_q, st_sel;
   lsu_size_t   st_size, tag_size;
   logic [1:0]  tag_off;

   assign op        = cu_op_t'(cuOP);
   assign mem_op    = is_load(op) | is_store(op);
   assign bad_align = mem_op & is_misaligned(op, addr[1:0]);
   assign st_size   = op_size(op);
   // Gated by nRst so the combinational stall also drops while reset is held.
   assign launch    = nRst & (state == IDLE) & en & mem_op & ~bad_align;
   assign ack       = (state == REQ) & bus.bus_ack;
   assign expire    = (state == REQ) & ~bus.bus_ack & (count == TO_W'(TIMEOUT - 1));

   lsu_lane_align u_align (
      .st_size   (st_size),
      .st_offset (addr[1:0]),
      .st_data   (rs2),
      .wdata     (st_wdata),
      .sel       (st_sel),
      .ld_size   (tag_size),
      .ld_offset (tag_off),
      .rdata     (bus.bus_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = REQ;
         REQ:     if (ack | expire) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      stall       = launch | (state == REQ);
      misaligned  = nRst & (state == IDLE) & en & bad_align;
      bus_err     = (state == DONE) & err_flag;
      bus.bus_req = (state == REQ);
   end

   // Bus fields are captured at launch and stay frozen for the whole REQ phase.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         sel_q    <= '0;
         tag_size <= SZ_BYTE;
         tag_off  <= '0;
         count    <= '0;
         err_flag <= 1'b0;
         memload  <= '0;
      end else if (launch) begin
         addr_q   <= {addr[31:2], 2'b00};
         we_q     <= is_store(op);
         wdata_q  <= st_wdata;
         sel_q    <= is_store(op) ? st_sel : 4'b1111;
         tag_size <= st_size;
         tag_off  <= addr[1:0];
         count    <= '0;
         err_flag <= 1'b0;
      end else if (state == REQ) begin
         if (ack) begin
            if (!we_q) memload <= ld_data;
         end else if (expire) begin
            err_flag <= 1'b1;
            if (!we_q) memload <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign bus.bus_addr  = addr_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_sel   = sel_q;

endmodule
